mux_rr_arb: RTL and testbench

Parametrised N-channel, W-bit arbitrating multiplexer with a registered output and valid/ready handshakes on every port. It replaces the fixed 4:1 single-bit select mux in the ALU datapath wherever several producers share one result bus. It chooses a channel itself, using either round-robin or fixed priority, instead of taking external select lines. It also reports which channel won and holds data stable under back-pressure.

---
 rtl/mux_rr_arb_if.sv | 27 ++
 rtl/mux_rr_arb.sv | 81 ++++++++
 tb/tb_mux_rr_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mux_rr_arb_if.sv
// Handshake bundle for mux_rr_arb: NUM_CH request channels in, one registered
// result channel out. The arbiter uses the slave view; the producer/consumer side uses master.
interface mux_rr_arb_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                    mode;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_rr_arb.sv
// N-channel arbitrating mux with a one-deep registered output. Round-robin or
// fixed-priority selection, winner index reported alongside the data.
module mux_rr_arb #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_rr_arb_if.slave  bus
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] win;
  logic [WIDTH-1:0] win_data;
  logic             any_vld;
  logic             load;
  logic             accept;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] sel_p1;

  // Stage 0: arbitration. The second loop overrides the first, so channels at or
  // above the search base take precedence over the wrapped-around ones.
  always_comb begin
    base = bus.mode ? '0 : rr_ptr;
    win  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && (i < int'(base))) win = SEL_W'(i);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && (i >= int'(base))) win = SEL_W'(i);
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == SEL_W'(i)) win_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign any_vld = |bus.in_valid;
  assign load    = !vld_p1 || bus.out_ready;
  assign accept  = rst_n && load && any_vld;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.in_ready[i] = accept && (win == SEL_W'(i));
    end
  end

  // Stage 1: output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      rr_ptr  <= '0;
    end else begin
      if (load) begin
        vld_p1 <= any_vld;
        if (any_vld) begin
          data_p1 <= win_data;
          sel_p1  <= win;
        end
      end
      if (accept && !bus.mode) begin
        rr_ptr <= (win == SEL_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_sel   = sel_p1;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb (WIDTH=8, NUM_CH=4): reset, rotation, skip/wrap,
// fixed priority, back-pressure and mid-transfer reset.
module tb_mux_rr_arb;
  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mux_rr_arb_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

  mux_rr_arb #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(d));
    chk({tag, ".out_sel"},   32'(bus.out_sel),   32'(s));
  endtask

  initial begin
    logic [1:0] s;
    n_chk  = 0;
    n_fail = 0;

    // Reset with every channel requesting and the consumer ready
    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 32'hA3A2A1A0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst.in_ready0", 32'(bus.in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst.in_ready", 32'(bus.in_ready), 32'h0);
    end
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    rst_n = 1'b1;
    #1;

    // Round-robin rotation over all four channels
    for (int k = 0; k < 8; k++) begin
      s = 2'(k % 4);
      chk("rr.in_ready", 32'(bus.in_ready), 32'(4'b0001 << s));
      tick();
      chk_out("rr", 1'b1, 8'hA0 + 8'(s), s);
    end

    // Skip idle channels; pointer wraps after channel 3
    bus.in_valid = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      s = (k % 2 == 1) ? 2'd3 : 2'd1;
      chk("skip.in_ready", 32'(bus.in_ready), 32'(4'b0001 << s));
      tick();
      chk_out("skip", 1'b1, 8'hA0 + 8'(s), s);
    end

    // Fixed priority: channel 1 always wins over 2 and 3
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1110;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("fix.in_ready", 32'(bus.in_ready), 32'h2);
      tick();
      chk_out("fix", 1'b1, 8'hA1, 2'd1);
    end

    // Load channel 2 with 0x5C (pointer still 0), pointer moves to 3
    bus.mode     = 1'b0;
    bus.in_valid = 4'b0100;
    bus.in_data  = 32'hA35CA1A0;
    tick();
    chk_out("bp.load", 1'b1, 8'h5C, 2'd2);

    // Stall with channels 0, 1, 3 pending
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1011;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp.in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      chk_out("bp.hold", 1'b1, 8'h5C, 2'd2);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(bus.in_ready), 32'h8);
    tick();
    chk_out("bp.release", 1'b1, 8'hA3, 2'd3);
    chk("bp.next.in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk_out("bp.next", 1'b1, 8'hA0, 2'd0);

    // Reset while holding a stalled beat; pointer was 1 before reset
    bus.in_data   = 32'hA3A2A1A0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk("mrst.in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk_out("mrst", 1'b0, 8'h00, 2'd0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("mrst.grant.in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk_out("mrst.grant", 1'b1, 8'hA0, 2'd0);

    // No requests: output goes invalid, data and select hold
    bus.in_valid = 4'b0000;
    #1;
    chk("idle.in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk_out("idle", 1'b0, 8'hA0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
